ext_bus_bridge: RTL and testbench

EXT_BUS_BRIDGE -- requirements
Module: ext_bus_bridge

---
 rtl/ext_bus_bridge.sv | 243 ++++++++++++++++++++++++
 tb/tb_ext_bus_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_bridge.sv
// ext_bus_bridge
//
// Bridges a word-wide CPU read/write request interface onto an 8-bit
// multiplexed external bus. Each transfer emits the high address byte
// (latch_hi), then the low address byte (latch_lo), and then walks the byte
// lanes F..L in ascending order. Every lane is held for 1+WAIT cycles.
// From the second lane on, ind is asserted so the external side advances
// its latched address by one.
//
// Parameters
//   RV    CPU data width in bits (16 or 32)
//   WAIT  extra hold cycles per data byte (0..15)
//
// Ports
//   clk              single clock, rising edge
//   reset_in         synchronous active-high reset
//   raddr/rreq       read word address / read request (level, held until rdone)
//   rdata/rdone      read data (updated lane by lane) / one-cycle done pulse
//   waddr/wmask      write word address / byte enables (nonzero = request)
//   wdata/wdone      write data / one-cycle done pulse
//   bus_out/bus_in   multiplexed address/data byte out, read byte in
//   latch_hi         high address byte strobe
//   latch_lo         low address byte strobe
//   write            external write strobe
//   ind              external address increment strobe
//
// All outputs are registered. The output logic looks at the next state and
// next lane, so the registered strobes line up with the state being entered.

module ext_bus_bridge #(
    parameter int RV   = 16,
    parameter int WAIT = 0,
    localparam int NB  = RV / 8,
    localparam int LB  = $clog2(RV / 8)
) (
    input  logic            clk,
    input  logic            reset_in,
    input  logic [15-LB:0]  raddr,
    input  logic            rreq,
    output logic [RV-1:0]   rdata,
    output logic            rdone,
    input  logic [15-LB:0]  waddr,
    input  logic [NB-1:0]   wmask,
    input  logic [RV-1:0]   wdata,
    output logic            wdone,
    output logic [7:0]      bus_out,
    input  logic [7:0]      bus_in,
    output logic            latch_hi,
    output logic            latch_lo,
    output logic            write,
    output logic            ind
);

    localparam logic [3:0]    WAIT_C    = 4'(WAIT);
    localparam logic [LB-1:0] LAST_LANE = LB'(NB - 1);
    localparam logic [LB-1:0] LANE_ONE  = LB'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AHI  = 3'd1,
        ALO  = 3'd2,
        XFER = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state;
    state_t        nxt_state;
    logic [LB-1:0] lane;
    logic [LB-1:0] nxt_lane;
    logic [3:0]    hcnt;
    logic [3:0]    nxt_hcnt;

    // Transfer context, captured while idle and frozen for the whole transfer.
    logic [15-LB:0] addr_q;
    logic [LB-1:0]  first_q;
    logic [LB-1:0]  last_q;
    logic           wr_q;
    logic [NB-1:0]  wmask_q;
    logic [RV-1:0]  wdata_q;

    // Request selection in IDLE; a write wins over a simultaneous read.
    logic [LB-1:0]  w_first;
    logic [LB-1:0]  w_last;
    logic           sel_wr;
    logic [15-LB:0] sel_addr;
    logic [LB-1:0]  sel_first;
    logic [LB-1:0]  sel_last;

    // Next values for the registered outputs.
    logic [7:0] nxt_bus;
    logic       nxt_latch_hi;
    logic       nxt_latch_lo;
    logic       nxt_write;
    logic       nxt_ind;
    logic       nxt_rdone;
    logic       nxt_wdone;

    // Lowest and highest set mask bits give the first and last write lanes.
    always_comb begin
        w_first = '0;
        w_last  = '0;
        for (int k = NB - 1; k >= 0; k--) begin
            if (wmask[k]) w_first = LB'(k);
        end
        for (int k = 0; k < NB; k++) begin
            if (wmask[k]) w_last = LB'(k);
        end
    end

    always_comb begin
        sel_wr    = |wmask;
        sel_addr  = sel_wr ? waddr : raddr;
        sel_first = sel_wr ? w_first : '0;
        sel_last  = sel_wr ? w_last : LAST_LANE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state <= IDLE;
            lane  <= '0;
            hcnt  <= '0;
        end else begin
            state <= nxt_state;
            lane  <= nxt_lane;
            hcnt  <= nxt_hcnt;
        end
    end

    // Next-state logic
    always_comb begin
        nxt_state = state;
        nxt_lane  = lane;
        nxt_hcnt  = hcnt;
        case (state)
            IDLE: begin
                if (sel_wr || rreq) nxt_state = AHI;
            end
            AHI: begin
                nxt_state = ALO;
            end
            ALO: begin
                nxt_state = XFER;
                nxt_lane  = first_q;
                nxt_hcnt  = '0;
            end
            XFER: begin
                if (hcnt == WAIT_C) begin
                    if (lane == last_q) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_lane = lane + LANE_ONE;
                        nxt_hcnt = '0;
                    end
                end else begin
                    nxt_hcnt = hcnt + 4'd1;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Output logic, evaluated for the state about to be entered. AHI is only
    // entered from IDLE, so it uses the live selection rather than the
    // captured context, which is loaded on that same edge.
    always_comb begin
        nxt_bus      = '0;
        nxt_latch_hi = 1'b0;
        nxt_latch_lo = 1'b0;
        nxt_write    = 1'b0;
        nxt_ind      = 1'b0;
        nxt_rdone    = 1'b0;
        nxt_wdone    = 1'b0;
        case (nxt_state)
            AHI: begin
                nxt_bus      = sel_addr[15-LB:8-LB];
                nxt_latch_hi = 1'b1;
            end
            ALO: begin
                nxt_bus      = {addr_q[7-LB:0], first_q};
                nxt_latch_lo = 1'b1;
            end
            XFER: begin
                nxt_ind = (nxt_lane != first_q);
                if (wr_q) begin
                    nxt_bus   = wdata_q[{nxt_lane, 3'b000} +: 8];
                    nxt_write = wmask_q[nxt_lane];
                end
            end
            DONE: begin
                nxt_rdone = ~wr_q;
                nxt_wdone = wr_q;
            end
            default: begin
            end
        endcase
    end

    // Output registers and read-lane sampling. A read lane is sampled on the
    // last cycle of its hold; lanes not yet reached keep their old bytes.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            bus_out  <= '0;
            latch_hi <= 1'b0;
            latch_lo <= 1'b0;
            write    <= 1'b0;
            ind      <= 1'b0;
            rdone    <= 1'b0;
            wdone    <= 1'b0;
            rdata    <= '0;
        end else begin
            bus_out  <= nxt_bus;
            latch_hi <= nxt_latch_hi;
            latch_lo <= nxt_latch_lo;
            write    <= nxt_write;
            ind      <= nxt_ind;
            rdone    <= nxt_rdone;
            wdone    <= nxt_wdone;
            if (state == XFER && !wr_q && hcnt == WAIT_C) begin
                rdata[{lane, 3'b000} +: 8] <= bus_in;
            end
        end
    end

    // Transfer context capture. Reloaded on every idle cycle, so the values
    // present on the request edge are what the transfer uses.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            addr_q  <= sel_addr;
            first_q <= sel_first;
            last_q  <= sel_last;
            wr_q    <= sel_wr;
            wmask_q <= wmask;
            wdata_q <= wdata;
        end
    end

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Bench for ext_bus_bridge. Three instances cover RV=16/WAIT=0,
// RV=16/WAIT=2 and RV=32/WAIT=1; one is active at a time (sel). Every
// transfer is expanded into an expected per-cycle output trace that is queued
// when the request is driven and compared cycle by cycle as the DUT runs.

module tb_ext_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_in;
    logic        rreq;
    logic [15:0] raddr;
    logic [15:0] waddr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [7:0]  bus_in;
    int          sel;

    int n_cmp = 0;
    int n_err = 0;

    // Instance 0: RV=16, WAIT=0
    logic        d0_rreq, d0_rdone, d0_wdone, d0_hi, d0_lo, d0_wr, d0_ind;
    logic [1:0]  d0_wmask;
    logic [15:0] d0_rdata;
    logic [7:0]  d0_bus;
    // Instance 1: RV=16, WAIT=2
    logic        d1_rreq, d1_rdone, d1_wdone, d1_hi, d1_lo, d1_wr, d1_ind;
    logic [1:0]  d1_wmask;
    logic [15:0] d1_rdata;
    logic [7:0]  d1_bus;
    // Instance 2: RV=32, WAIT=1
    logic        d2_rreq, d2_rdone, d2_wdone, d2_hi, d2_lo, d2_wr, d2_ind;
    logic [3:0]  d2_wmask;
    logic [31:0] d2_rdata;
    logic [7:0]  d2_bus;

    assign d0_rreq  = rreq && (sel == 0);
    assign d1_rreq  = rreq && (sel == 1);
    assign d2_rreq  = rreq && (sel == 2);
    assign d0_wmask = (sel == 0) ? wmask[1:0] : 2'b00;
    assign d1_wmask = (sel == 1) ? wmask[1:0] : 2'b00;
    assign d2_wmask = (sel == 2) ? wmask : 4'b0000;

    ext_bus_bridge #(.RV(16), .WAIT(0)) u_d0 (
        .clk(clk), .reset_in(reset_in), .raddr(raddr[14:0]), .rreq(d0_rreq),
        .rdata(d0_rdata), .rdone(d0_rdone), .waddr(waddr[14:0]), .wmask(d0_wmask),
        .wdata(wdata[15:0]), .wdone(d0_wdone), .bus_out(d0_bus), .bus_in(bus_in),
        .latch_hi(d0_hi), .latch_lo(d0_lo), .write(d0_wr), .ind(d0_ind)
    );

    ext_bus_bridge #(.RV(16), .WAIT(2)) u_d1 (
        .clk(clk), .reset_in(reset_in), .raddr(raddr[14:0]), .rreq(d1_rreq),
        .rdata(d1_rdata), .rdone(d1_rdone), .waddr(waddr[14:0]), .wmask(d1_wmask),
        .wdata(wdata[15:0]), .wdone(d1_wdone), .bus_out(d1_bus), .bus_in(bus_in),
        .latch_hi(d1_hi), .latch_lo(d1_lo), .write(d1_wr), .ind(d1_ind)
    );

    ext_bus_bridge #(.RV(32), .WAIT(1)) u_d2 (
        .clk(clk), .reset_in(reset_in), .raddr(raddr[13:0]), .rreq(d2_rreq),
        .rdata(d2_rdata), .rdone(d2_rdone), .waddr(waddr[13:0]), .wmask(d2_wmask),
        .wdata(wdata), .wdone(d2_wdone), .bus_out(d2_bus), .bus_in(bus_in),
        .latch_hi(d2_hi), .latch_lo(d2_lo), .write(d2_wr), .ind(d2_ind)
    );

    // Observed vector of the selected instance: {rdata, bus, hi, lo, wr, ind, rdone, wdone}
    logic [45:0] obs;
    always_comb begin
        obs = '0;
        case (sel)
            0: obs = {16'h0, d0_rdata, d0_bus, d0_hi, d0_lo, d0_wr, d0_ind, d0_rdone, d0_wdone};
            1: obs = {16'h0, d1_rdata, d1_bus, d1_hi, d1_lo, d1_wr, d1_ind, d1_rdone, d1_wdone};
            2: obs = {d2_rdata, d2_bus, d2_hi, d2_lo, d2_wr, d2_ind, d2_rdone, d2_wdone};
            default: obs = '0;
        endcase
    end

    typedef struct {
        logic [45:0] v;      // expected output vector for this cycle
        bit          smp;    // this cycle is the sampling cycle of a read lane
        logic [7:0]  b;      // byte to present on bus_in when smp
        bit          rel_w;  // drop wmask after this cycle
        bit          rel_r;  // drop rreq after this cycle
        bit          scr;    // scramble address/data inputs after this cycle
    } ent_t;

    ent_t exp_q[$];

    // Reference model state
    logic [31:0] mrd [3];
    int nbv [3] = '{2, 2, 4};
    int lbv [3] = '{1, 1, 2};
    int wtv [3] = '{0, 2, 1};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [45:0] mk(input logic [31:0] rd, input logic [7:0] b,
                                       input logic hi, input logic lo, input logic wr,
                                       input logic inc, input logic rdn, input logic wdn);
        return {rd, b, hi, lo, wr, inc, rdn, wdn};
    endfunction

    function automatic ent_t blank();
        ent_t e;
        e.v = '0; e.smp = 1'b0; e.b = '0; e.rel_w = 1'b0; e.rel_r = 1'b0; e.scr = 1'b0;
        return e;
    endfunction

    task automatic push_idle(input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e = blank();
            e.v = mk(mrd[sel], 8'h00, 0, 0, 0, 0, 0, 0);
            exp_q.push_back(e);
        end
    endtask

    // Expand one transfer into its expected cycle trace (AHI .. DONE).
    task automatic push_trace(input bit wr, input logic [15:0] addr, input logic [3:0] mask,
                              input logic [31:0] data, input logic [31:0] rb,
                              input bit rel, input bit scr);
        int f, l, nb, lb, wt;
        logic [15:0] ba;
        logic [7:0]  byt;
        ent_t e;
        nb = nbv[sel]; lb = lbv[sel]; wt = wtv[sel];
        f = -1; l = 0;
        if (wr) begin
            for (int k = 0; k < nb; k++) begin
                if (mask[k]) begin
                    if (f < 0) f = k;
                    l = k;
                end
            end
        end else begin
            f = 0; l = nb - 1;
        end
        ba = 16'((addr << lb) | f);
        e = blank(); e.v = mk(mrd[sel], ba[15:8], 1, 0, 0, 0, 0, 0); e.scr = scr;
        exp_q.push_back(e);
        e = blank(); e.v = mk(mrd[sel], ba[7:0], 0, 1, 0, 0, 0, 0);
        exp_q.push_back(e);
        for (int k = f; k <= l; k++) begin
            for (int h = 0; h <= wt; h++) begin
                e = blank();
                byt = wr ? data[8*k +: 8] : 8'h00;
                e.v = mk(mrd[sel], byt, 0, 0, wr && mask[k], k != f, 0, 0);
                if (!wr && h == wt) begin
                    e.smp = 1'b1;
                    e.b = rb[8*k +: 8];
                end
                exp_q.push_back(e);
                if (!wr && h == wt) mrd[sel][8*k +: 8] = rb[8*k +: 8];
            end
        end
        e = blank(); e.v = mk(mrd[sel], 8'h00, 0, 0, 0, 0, !wr, wr);
        e.rel_w = rel && wr; e.rel_r = rel && !wr;
        exp_q.push_back(e);
    endtask

    // Pop and compare up to n queued cycles; inputs change on the falling edge.
    task automatic run_n(input int n, input string tag);
        ent_t e;
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < n) begin
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            if (e.smp) bus_in = e.b;
            else bus_in = 8'($urandom);
            chk($sformatf("%s[%0d]", tag, i), {18'h0, obs}, {18'h0, e.v});
            if (e.scr) begin
                waddr = 16'($urandom);
                raddr = 16'($urandom);
                wdata = $urandom;
            end
            if (e.rel_w) wmask = 4'b0000;
            if (e.rel_r) rreq = 1'b0;
            i++;
        end
    endtask

    task automatic run_all(input string tag);
        run_n(100000, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr;
        logic [15:0] a;
        logic [3:0]  m;
        logic [31:0] d, rb;

        reset_in = 1'b1; rreq = 1'b0; raddr = '0; waddr = '0; wmask = '0;
        wdata = '0; bus_in = '0; sel = 0;
        for (int s = 0; s < 3; s++) mrd[s] = '0;
        repeat (2) @(negedge clk);

        // Reset state of every instance
        for (int s = 0; s < 3; s++) begin
            sel = s;
            push_idle(1);
            run_all($sformatf("reset%0d", s));
        end

        // RV=16 WAIT=0 write of both lanes, request sampled right after reset
        reset_in = 1'b0;
        sel = 0;
        waddr = 16'h1234; wdata = 32'h0000BEEF; wmask = 4'b0011;
        push_trace(1, 16'h1234, 4'b0011, 32'h0000BEEF, 0, 1, 1);
        push_idle(1);
        run_all("wr16");

        // RV=16 WAIT=2 read, lanes held three cycles
        sel = 1;
        raddr = 16'h0010; rreq = 1'b1;
        push_trace(0, 16'h0010, 4'b0000, 0, 32'h0000AA55, 1, 1);
        push_idle(1);
        run_all("rd16w2");

        // RV=32 sparse mask with a gap lane
        sel = 2;
        waddr = 16'h0100; wdata = 32'h11223344; wmask = 4'b1010;
        push_trace(1, 16'h0100, 4'b1010, 32'h11223344, 0, 1, 1);
        push_idle(1);
        run_all("wr32gap");

        // Simultaneous read and write: write first, then the read from IDLE
        sel = 0;
        raddr = 16'h0ABC; rreq = 1'b1;
        waddr = 16'h0055; wdata = 32'h0000C3A5; wmask = 4'b0001;
        push_trace(1, 16'h0055, 4'b0001, 32'h0000C3A5, 0, 1, 0);
        push_idle(1);
        push_trace(0, 16'h0ABC, 4'b0000, 0, 32'h00007E81, 1, 0);
        push_idle(1);
        run_all("prio");

        // Write mask held through DONE: one pulse, next transfer after an idle cycle
        sel = 2;
        waddr = 16'h2A5C; wdata = 32'hCAFE0123; wmask = 4'b0100;
        push_trace(1, 16'h2A5C, 4'b0100, 32'hCAFE0123, 0, 0, 0);
        push_idle(1);
        push_trace(1, 16'h2A5C, 4'b0100, 32'hCAFE0123, 0, 1, 0);
        push_idle(2);
        run_all("held");

        // Reset pulse in the middle of a read: abort, clear, then a clean write
        sel = 1;
        raddr = 16'h0333; rreq = 1'b1;
        push_trace(0, 16'h0333, 4'b0000, 0, 32'h00005AC3, 1, 0);
        run_n(6, "abort_pre");
        exp_q.delete();
        reset_in = 1'b1; rreq = 1'b0;
        for (int s = 0; s < 3; s++) mrd[s] = '0;
        push_idle(1);
        run_all("abort_rst");
        reset_in = 1'b0;
        waddr = 16'h0777; wdata = 32'h00009D4E; wmask = 4'b0010;
        push_trace(1, 16'h0777, 4'b0010, 32'h00009D4E, 0, 1, 1);
        push_idle(2);
        run_all("abort_post");

        // Random transfers on every instance, inputs scrambled after capture
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int t = 0; t < 5; t++) begin
                wr = 1'($urandom_range(0, 1));
                a  = 16'($urandom);
                m  = 4'($urandom_range(1, (1 << nbv[s]) - 1));
                d  = $urandom;
                rb = $urandom;
                if (wr) begin
                    waddr = a; wmask = m; wdata = d;
                end else begin
                    raddr = a; rreq = 1'b1;
                end
                push_trace(wr, a, m, d, rb, 1, 1);
                push_idle(1);
                run_all($sformatf("rnd%0d_%0d", s, t));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
